drum_hit_arbiter: RTL and testbench

- Round-robin scheduler that shares one sample player/sprite-animation engine among 14 drum pads.
- Captures rising edges on per-pad hit lines, queues them as pending requests, grants one pad at a time, then waits for the player's completion handshake.
- Pad IDs use the same 1..14 encoding as the sprite image select path; 0 means none.
- Sits between the per-sprite collision/hit detectors and the shared audio/animation player.

---
 rtl/drum_hit_arbiter.sv | 153 +++++++++++++++
 tb/tb_drum_hit_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_hit_arbiter.sv
// drum_hit_arbiter
//   Round-robin scheduler that shares one sample player / sprite-animation engine
//   among N_PADS drum pads. Rising edges on the hit lines are queued as pending
//   requests. One pad at a time is granted, and the block then waits for the
//   player's completion strobe, or abandons the grant after TIMEOUT_CYCLES.
//   A GAP_CYCLES dead time follows every grant.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   hit          per-pad hit level; a rising edge is a request
//   enable       1 = new grants allowed (edge capture always runs)
//   play_done    one-cycle completion strobe from the player
//   play_start   one-cycle strobe: the player starts the sample for play_id
//   play_id      granted pad ID (1..N_PADS); 0 when no grant is active
//   pending      queued requests; bit i is pad ID i+1
//   busy         high in any state other than idle
//   timeout_err  one-cycle pulse when a grant is abandoned by timeout

module drum_hit_arbiter #(
    parameter int unsigned N_PADS         = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PADS-1:0] hit,
    input  logic              enable,
    input  logic              play_done,
    output logic              play_start,
    output logic [3:0]        play_id,
    output logic [N_PADS-1:0] pending,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES + 1) ?
                                      TIMEOUT_CYCLES : GAP_CYCLES + 1;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    // A zero-length gap still spends one cycle in StGap.
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_t;

    state_t            state_q, state_d;
    logic [N_PADS-1:0] hit_q;
    logic [N_PADS-1:0] pending_q, pending_d;
    logic [N_PADS-1:0] rise, clr;
    logic [3:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        id_q, id_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              win_found;
    logic [3:0]        win_idx;

    assign rise = hit & ~hit_q;

    // Only the START cycle clears the granted bit; a coincident rise re-queues it.
    always_comb begin
        clr = '0;
        if (state_q == StStart && id_q != 4'd0) begin
            clr[id_q - 4'd1] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    // Search starts just after the last granted pad and wraps around.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_PADS; i++) begin
            idx = 32'(rr_ptr_q) + 1 + i;
            if (idx >= N_PADS) begin
                idx = idx - N_PADS;
            end
            if (!win_found && pending_q[idx]) begin
                win_found = 1'b1;
                win_idx   = 4'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && win_found) begin
                    state_d  = StStart;
                    rr_ptr_d = win_idx;
                    id_d     = win_idx + 4'd1;
                end
            end
            StStart: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (play_done) begin
                    state_d = StGap;
                    id_d    = 4'd0;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err = 1'b1;
                    state_d     = StGap;
                    id_d        = 4'd0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hit_q     <= '0;
            pending_q <= '0;
            rr_ptr_q  <= 4'(N_PADS - 1);
            id_q      <= 4'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign play_start = (state_q == StStart);
    assign play_id    = id_q;
    assign pending    = pending_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_drum_hit_arbiter.sv
// tb_drum_hit_arbiter
//   Directed stimulus for drum_hit_arbiter with a small cycle model kept in
//   terms of request sets, grant age and remaining gap length. All outputs are
//   compared against the model on every falling edge, and hand-computed
//   expectations pin key points of each scenario.

module tb_drum_hit_arbiter;

    localparam int unsigned NP  = 14;
    localparam int unsigned TO  = 8;
    localparam int unsigned GAP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] hit;
    logic          enable;
    logic          play_done;
    logic          play_start;
    logic [3:0]    play_id;
    logic [NP-1:0] pending;
    logic          busy;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;

    drum_hit_arbiter #(
        .N_PADS        (NP),
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hit        (hit),
        .enable     (enable),
        .play_done  (play_done),
        .play_start (play_start),
        .play_id    (play_id),
        .pending    (pending),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_START = 1, M_WAIT = 2, M_GAP = 3;
    int            m_mode;
    int            m_age;       // cycles since the START cycle
    int            m_gap_left;  // gap cycles still to spend
    int            m_ptr;       // last granted pad index
    int            m_id;
    logic [NP-1:0] m_pend;
    logic [NP-1:0] m_prev;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = M_IDLE; m_age = 0; m_gap_left = 0; m_ptr = NP - 1;
                m_id = 0; m_pend = '0; m_prev = '0;
            end else begin
                logic [NP-1:0] nxt;
                nxt = m_pend;
                if (m_mode == M_START) nxt[m_id-1] = 1'b0;
                nxt = nxt | (hit & ~m_prev);
                m_prev = hit;
                case (m_mode)
                    M_IDLE: begin
                        if (enable && m_pend != '0) begin
                            for (int k = 1; k <= NP; k++) begin
                                if (m_pend[(m_ptr + k) % NP]) begin
                                    m_ptr  = (m_ptr + k) % NP;
                                    m_id   = m_ptr + 1;
                                    m_mode = M_START;
                                    break;
                                end
                            end
                        end
                    end
                    M_START: begin m_mode = M_WAIT; m_age = 1; end
                    M_WAIT: begin
                        if (play_done || m_age == TO) begin
                            m_mode     = M_GAP;
                            m_gap_left = (GAP == 0) ? 1 : GAP;
                            m_id       = 0;
                        end else begin
                            m_age++;
                        end
                    end
                    default: begin
                        m_gap_left--;
                        if (m_gap_left == 0) m_mode = M_IDLE;
                    end
                endcase
                m_pend = nxt;
            end
        end
    end

    // Compare process: every falling edge, all outputs.
    initial begin
        forever begin
            @(negedge clk);
            check("play_start", 32'(play_start), 32'(m_mode == M_START));
            check("play_id", 32'(play_id), 32'(m_id));
            check("pending", 32'(pending), 32'(m_pend));
            check("busy", 32'(busy), 32'(m_mode != M_IDLE));
            check("timeout_err", 32'(timeout_err),
                  32'(m_mode == M_WAIT && !play_done && m_age == TO));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input logic [3:0] exp_id, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (play_start || n > 60) break;
            n++;
        end
        if (play_start) check(name, 32'(play_id), 32'(exp_id));
        else check({name, " start seen"}, 32'd0, 32'd1);
    endtask

    task automatic done_after(input int d);
        repeat (d) next_cycle();
        play_done = 1'b1;
        next_cycle();
        play_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy || n > 60) break;
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; hit = '0; enable = 1'b1; play_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset play_id", 32'(play_id), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Single rise on pad 1: pending after edge k, START after edge k+1.
        next_cycle();
        hit[0] = 1'b1;
        @(negedge clk);
        check("s1 pending before k", 32'(pending), 32'h0);
        next_cycle();
        @(negedge clk);
        check("s1 pending at k+1", 32'(pending), 32'h1);
        check("s1 no start yet", 32'(play_start), 32'd0);
        next_cycle();
        @(negedge clk);
        check("s1 start", 32'(play_start), 32'd1);
        check("s1 id", 32'(play_id), 32'd1);
        next_cycle();
        @(negedge clk);
        check("s1 pending cleared", 32'(pending), 32'h0);
        check("s1 start one cycle", 32'(play_start), 32'd0);
        check("s1 busy in wait", 32'(busy), 32'd1);
        done_after(1);
        hit = '0;
        wait_idle("s1 idle");

        // Three simultaneous requests, then a wrap back to pad 3.
        next_cycle();
        hit = 14'h2024;
        wait_start(4'd3, "s2 first id");
        next_cycle();
        hit = '0;
        done_after(4);
        wait_start(4'd6, "s2 second id");
        done_after(5);
        wait_start(4'd14, "s2 third id");
        next_cycle();
        hit[2] = 1'b1;
        done_after(4);
        wait_start(4'd3, "s2 wrap id");
        next_cycle();
        hit = '0;
        done_after(4);
        wait_idle("s2 idle");

        // Held level gives one request; a fresh rise during WAIT re-queues.
        next_cycle();
        hit[4] = 1'b1;
        wait_start(4'd5, "s3 id");
        done_after(5);
        wait_idle("s3 idle");
        check("s3 no requeue while held", 32'(pending), 32'h0);
        repeat (30) next_cycle();
        hit[4] = 1'b0;
        next_cycle();
        hit[4] = 1'b1;
        wait_start(4'd5, "s3 second id");
        next_cycle();
        hit[4] = 1'b0;
        next_cycle();
        hit[4] = 1'b1;
        next_cycle();
        @(negedge clk);
        check("s3 requeued in wait", 32'(pending), 32'h10);
        done_after(3);
        wait_start(4'd5, "s3 regrant id");
        next_cycle();
        hit = '0;
        done_after(3);
        wait_idle("s3 end idle");

        // Timeout: no play_done on pad 9.
        next_cycle();
        hit[8] = 1'b1; hit[9] = 1'b1;
        wait_start(4'd9, "s4 id");
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (timeout_err || n > 20) break;
        end
        check("s4 timeout latency", 32'(n), 32'd8);
        next_cycle();
        hit = '0;
        wait_start(4'd10, "s4 next id");
        done_after(2);
        wait_idle("s4 idle");

        // enable=0 holds off grants while capture continues.
        next_cycle();
        enable = 1'b0;
        hit[0] = 1'b1; hit[6] = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (play_start) n++;
        end
        check("s5 pending held", 32'(pending), 32'h41);
        check("s5 no start", 32'(n), 32'd0);
        next_cycle();
        enable = 1'b1;
        hit = '0;
        wait_start(4'd1, "s5 first id");
        done_after(2);
        wait_start(4'd7, "s5 second id");
        done_after(2);
        wait_idle("s5 idle");

        // Reset during WAIT with pad 14 re-queued.
        next_cycle();
        hit[13] = 1'b1;
        wait_start(4'd14, "s6 id");
        next_cycle();
        hit = '0;
        next_cycle();
        hit[13] = 1'b1;
        next_cycle();
        @(negedge clk);
        check("s6 pending", 32'(pending), 32'h2000);
        next_cycle();
        reset = 1'b1;
        hit = '0;
        #2;
        check("s6 rst play_start", 32'(play_start), 32'd0);
        check("s6 rst play_id", 32'(play_id), 32'd0);
        check("s6 rst pending", 32'(pending), 32'd0);
        check("s6 rst busy", 32'(busy), 32'd0);
        check("s6 rst timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) next_cycle();
        reset = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (play_start) n++;
        end
        check("s6 no start after reset", 32'(n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
